// File: rtl/vip_pkg.sv
// Shared types and sizes for the edge-detection VIP chain.
// The window struct is also consumed by the Sobel gradient stage.
package vip_pkg;

    localparam int PIX_W = 8;
    localparam int CNT_W = 11;

    typedef struct packed {
        logic [PIX_W-1:0] p11;
        logic [PIX_W-1:0] p12;
        logic [PIX_W-1:0] p13;
        logic [PIX_W-1:0] p21;
        logic [PIX_W-1:0] p22;
        logic [PIX_W-1:0] p23;
        logic [PIX_W-1:0] p31;
        logic [PIX_W-1:0] p32;
        logic [PIX_W-1:0] p33;
    } win3x3_t;

    typedef struct packed {
        logic vsync;
        logic href;
        logic clken;
    } sync_t;

endpackage

// File: rtl/sync_delay_2.sv
// Two-stage delay of the {vsync, href, clken} frame syncs, exposing both taps
// so a stage can use the aligned syncs and the outgoing syncs side by side.
module sync_delay_2
    import vip_pkg::*;
(
    input  logic  clock,
    input  logic  reset,
    input  sync_t sync_p0,
    output sync_t sync_p1,
    output sync_t sync_p2
);

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_p1 <= '0;
            sync_p2 <= '0;
        end else begin
            sync_p1 <= sync_p0;
            sync_p2 <= sync_p1;
        end
    end

endmodule

// File: rtl/matrix_3x3_window_8bit.sv
// Assembles a sliding 3x3 pixel window from the current row and two line-buffer
// taps, with 2-cycle delay-matched syncs and a valid flag masking border windows.
module matrix_3x3_window_8bit
    import vip_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 11
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              per_frame_vsync,
    input  logic              per_frame_href,
    input  logic              per_img_clken,
    input  logic [DATA_W-1:0] per_img_y,
    input  logic [DATA_W-1:0] taps0x,
    input  logic [DATA_W-1:0] taps1x,
    output logic              post_frame_vsync,
    output logic              post_frame_href,
    output logic              post_img_clken,
    output logic              post_win_valid,
    output logic [DATA_W-1:0] matrix_p11,
    output logic [DATA_W-1:0] matrix_p12,
    output logic [DATA_W-1:0] matrix_p13,
    output logic [DATA_W-1:0] matrix_p21,
    output logic [DATA_W-1:0] matrix_p22,
    output logic [DATA_W-1:0] matrix_p23,
    output logic [DATA_W-1:0] matrix_p31,
    output logic [DATA_W-1:0] matrix_p32,
    output logic [DATA_W-1:0] matrix_p33
);

    if (DATA_W != PIX_W) begin : g_bad_width
        $error("matrix_3x3_window_8bit: DATA_W must equal PIX_W");
    end

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    sync_t             sync_p0;
    sync_t             sync_p1;
    sync_t             sync_p2;
    logic [DATA_W-1:0] row3_p1;
    logic              hist_p1;
    logic              hist_p2;
    win3x3_t           win_p2;
    logic              vld_p2;
    logic [CNT_W-1:0]  row_cnt;
    logic [CNT_W-1:0]  col_cnt;
    logic              frame_locked;
    logic              vsync_rise;
    logic              href_fall;

    assign sync_p0 = {per_frame_vsync, per_frame_href, per_img_clken};

    sync_delay_2 u_sync_delay (
        .clock   (clock),
        .reset   (reset),
        .sync_p0 (sync_p0),
        .sync_p1 (sync_p1),
        .sync_p2 (sync_p2)
    );

    // Stage p1: current-row pixel aligned with the line-buffer taps.
    always_ff @(posedge clock) begin
        if (reset) begin
            row3_p1 <= '0;
        end else begin
            row3_p1 <= per_img_y;
        end
    end

    // Edges compare p1 against p2; p2 holds real history only two clocks after
    // reset, otherwise a vsync held high through reset would look like a rise.
    always_ff @(posedge clock) begin
        if (reset) begin
            hist_p1 <= 1'b0;
            hist_p2 <= 1'b0;
        end else begin
            hist_p1 <= 1'b1;
            hist_p2 <= hist_p1;
        end
    end

    assign vsync_rise = hist_p2 & sync_p1.vsync & ~sync_p2.vsync;
    assign href_fall  = hist_p2 & ~sync_p1.href & sync_p2.href;

    always_ff @(posedge clock) begin
        if (reset) begin
            row_cnt      <= '0;
            col_cnt      <= '0;
            frame_locked <= 1'b0;
        end else if (vsync_rise) begin
            row_cnt      <= '0;
            col_cnt      <= '0;
            frame_locked <= 1'b1;
        end else if (href_fall) begin
            row_cnt <= sat_inc(row_cnt);
            col_cnt <= '0;
        end else if (sync_p1.href && sync_p1.clken) begin
            col_cnt <= sat_inc(col_cnt);
        end
    end

    // Stage p2: window shift and border-masked valid.
    always_ff @(posedge clock) begin
        if (reset) begin
            win_p2 <= '0;
            vld_p2 <= 1'b0;
        end else begin
            vld_p2 <= sync_p1.clken && frame_locked &&
                      (row_cnt >= CNT_W'(2)) && (col_cnt >= CNT_W'(2));
            if (!sync_p1.href) begin
                win_p2 <= '0;
            end else if (sync_p1.clken) begin
                win_p2.p11 <= win_p2.p12;
                win_p2.p12 <= win_p2.p13;
                win_p2.p13 <= taps1x;
                win_p2.p21 <= win_p2.p22;
                win_p2.p22 <= win_p2.p23;
                win_p2.p23 <= taps0x;
                win_p2.p31 <= win_p2.p32;
                win_p2.p32 <= win_p2.p33;
                win_p2.p33 <= row3_p1;
            end
        end
    end

    assign post_frame_vsync = sync_p2.vsync;
    assign post_frame_href  = sync_p2.href;
    assign post_img_clken   = sync_p2.clken;
    assign post_win_valid   = vld_p2;

    assign matrix_p11 = win_p2.p11;
    assign matrix_p12 = win_p2.p12;
    assign matrix_p13 = win_p2.p13;
    assign matrix_p21 = win_p2.p21;
    assign matrix_p22 = win_p2.p22;
    assign matrix_p23 = win_p2.p23;
    assign matrix_p31 = win_p2.p31;
    assign matrix_p32 = win_p2.p32;
    assign matrix_p33 = win_p2.p33;

endmodule

// File: doc/matrix_3x3_window_8bit.md
Name: matrix_3x3_window_8bit

Overview:
- Downstream neighbour of the two-line shift RAM in the edge-detection VIP chain.
- Consumes the current-row pixel stream plus the two delayed-row taps from the line buffer, and assembles a sliding 3x3 pixel window.
- Emits the window with delay-matched frame syncs and a window-valid flag that masks incomplete border windows.
- Feeds the Sobel gradient stage.

Parameters:
- DATA_W, 8: pixel width. Fixed to 8 for this block; the parameter exists for assertion only.
- CNT_W, 11: width of the row and column counters. Supports up to 2047 pixels/lines.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- per_frame_vsync  in  1  input frame sync, high during the frame.
- per_frame_href  in  1  input line valid.
- per_img_clken  in  1  input pixel strobe.
- per_img_y  in  8  current-row pixel.
- taps0x  in  8  previous-row pixel from line buffer. Valid one cycle after the matching per_img_clken.
- taps1x  in  8  row-before-previous pixel. Same timing as taps0x.
- post_frame_vsync  out  1  vsync delayed 2 cycles.
- post_frame_href  out  1  href delayed 2 cycles.
- post_img_clken  out  1  clken delayed 2 cycles.
- post_win_valid  out  1  high with post_img_clken only when the window holds 3 real rows and 3 real columns.
- matrix_p11..p13  out  8 each  top row (oldest line), left to right.
- matrix_p21..p23  out  8 each  middle row.
- matrix_p31..p33  out  8 each  bottom row (current line).

Behaviour:
- Reset (synchronous, priority over everything):
  - All outputs are 0, including all nine matrix registers.
  - Delay pipes, row_cnt and col_cnt are 0.
  - frame_locked = 0.
- Alignment stage (cycle T+1 for a pixel presented at T):
  - Register per_img_y into row3_d. This aligns it with taps0x/taps1x.
  - Register vsync, href and clken into stage-1 delays.
- Window stage (cycle T+2):
  - Stage-1 href low: all nine matrix registers clear to 0.
  - Stage-1 href high and stage-1 clken high: each row shifts left.
    - p11<=p12, p12<=p13, p13<=taps1x.
    - p21<=p22, p22<=p23, p23<=taps0x.
    - p31<=p32, p32<=p33, p33<=row3_d.
  - Stage-1 href high and clken low: the window holds.
- Latency: exactly 2 cycles from input strobe to post_* outputs. post_frame_vsync/href/clken are pure 2-cycle delays.
- Counters, clocked on stage-1 signals:
  - vsync rising edge: row_cnt<=0, col_cnt<=0, frame_locked<=1.
  - href falling edge: row_cnt<=row_cnt+1 (saturates at all-ones), col_cnt<=0.
  - Each stage-1 clken while href is high: col_cnt<=col_cnt+1 (saturates).
  - Simultaneous vsync rise and href fall: the vsync clear wins.
- post_win_valid is registered alongside the matrix and is high only when all hold:
  - stage-1 clken
  - frame_locked
  - row_cnt>=2
  - col_cnt (pre-increment) >=2
- First two lines of a frame and first two pixels of every line produce post_win_valid=0. The matrix still updates.
- Reset mid-frame:
  - frame_locked=0, so post_win_valid stays 0 until the next vsync rising edge.
  - Delayed syncs resume passing through immediately after reset is released.
- clken gaps within a line: the window and col_cnt hold; no valid is emitted for gap cycles.
- Line with fewer than 3 pixels: no valid windows on that line. row_cnt still increments.

Decomposition:
- Shared package vip_pkg holds:
  - PIX_W=8 and CNT_W=11.
  - A typedef for the 3x3 window struct (p11..p33), reused by the Sobel stage.
- One natural sub-module: sync_delay_2, a 2-stage delay of {vsync, href, clken}. Also reused by downstream stages.
- The line buffer is not instantiated here. Its outputs arrive as ports, and the wrapper connects them.

Test Plan:
- Reset held for 3 cycles mid-stream -> all outputs 0. After release, post_win_valid stays 0 until the next vsync rise, even while href/clken toggle.
- 5x5 frame, pixel value = 10*row+col, with the line-buffer model supplying taps -> at row 2, col 2 (post_win_valid first high) the window is p11=0, p12=1, p13=2, p21=10, p22=11, p23=12, p31=20, p32=21, p33=22. Exactly 9 valid windows are emitted per frame.
- Latency check: a single clken pulse at cycle 100 -> post_img_clken high at cycle 102 only. post_frame_href/vsync edges lag the inputs by exactly 2 cycles.
- clken high every other cycle on a 6-pixel line -> the window shifts only on strobes. Valid windows = 4 per full line from row 2 onward, with none in gap cycles.
- href low between lines -> matrix reads 0 on the cycle after the stage-1 href fall. row_cnt increments once per line. col_cnt restarts, so the first 2 strobes of each line have post_win_valid=0.
- vsync rise coinciding with an href fall -> row_cnt=0 on the next cycle, with no increment. The first two lines of the new frame produce no valid windows.
